// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg
//   Elastic pipeline-stage register with a valid/ready handshake.
//   A two-entry store (main + skid) keeps full throughput even though
//   in_ready is registered, so there is no combinational path from
//   out_ready to in_ready. A synchronous flush squashes every held entry.
//   The payload is carried opaquely.
//
// Parameters
//   DATA_W   payload width in bits
//   RST_VAL  reset value of out_data and the skid entry
//   CNT_W    performance counter width (only with PIPE_STAGE_PERF_EN)
//
// Ports
//   clk, rst    clock (rising edge) and asynchronous active-high reset
//   flush       squash all held entries at the next edge
//   in_valid    upstream holds a valid payload
//   in_ready    stage can accept; registered
//   in_data     upstream payload
//   out_valid   out_data is valid; registered
//   out_ready   downstream accepts this cycle
//   out_data    payload to downstream; registered
//   stall_cnt   cycles with out_valid & ~out_ready (PIPE_STAGE_PERF_EN)
//   bubble_cnt  cycles with ~out_valid (PIPE_STAGE_PERF_EN)
//
// Configuration macro
//   PIPE_STAGE_PERF_EN  adds the saturating stall/bubble counters and ports.
//                       When undefined the handshake is identical and the
//                       counters do not exist.

module pipe_stage_skid_reg #(
  parameter int unsigned        DATA_W  = 32,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
`ifdef PIPE_STAGE_PERF_EN
  ,
  parameter int unsigned        CNT_W   = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  // Occupancy of the stage: nothing held, main only, main plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] skid_data;
  logic [DATA_W-1:0] main_nxt;
  logic [DATA_W-1:0] skid_nxt;
  logic              in_ready_nxt;
  logic              out_valid_nxt;
  logic              accept_c;
  logic              deliver_c;

  // Handshake events, both taking effect at the coming edge.
  assign accept_c  = in_valid & in_ready;
  assign deliver_c = out_valid & out_ready;

  // State and datapath registers. out_data is the main entry itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= RST_VAL;
      skid_data <= RST_VAL;
    end else begin
      state     <= state_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= main_nxt;
      skid_data <= skid_nxt;
    end
  end

  // Next-state and datapath steering.
  always_comb begin
    state_nxt = state;
    main_nxt  = out_data;
    skid_nxt  = skid_data;

    if (flush) begin
      // Only the occupancy is cleared; stale data stays behind out_valid=0.
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept_c) begin
            state_nxt = ONE;
            main_nxt  = in_data;
          end
        end

        ONE: begin
          if (accept_c && deliver_c) begin
            main_nxt = in_data;
          end else if (accept_c) begin
            // Downstream stalled: park the newcomer behind the main entry.
            state_nxt = TWO;
            skid_nxt  = in_data;
          end else if (deliver_c) begin
            state_nxt = EMPTY;
          end
        end

        TWO: begin
          // in_ready is low here, so no accept can occur.
          if (deliver_c) begin
            state_nxt = ONE;
            main_nxt  = skid_data;
          end
        end

        default: begin
          state_nxt = EMPTY;
        end
      endcase
    end

    // Flags are decoded from the next state so they can be registered.
    in_ready_nxt  = (state_nxt != TWO);
    out_valid_nxt = (state_nxt != EMPTY);
  end

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating stall/bubble counters; only rst clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (!out_valid && (bubble_cnt != CNT_MAX)) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb_pipe_stage_skid_reg
//   Self-checking bench for pipe_stage_skid_reg. A negedge monitor pushes
//   every accepted payload into a scoreboard queue and pops/compares on every
//   delivery; directed checks cover reset, streaming, backpressure, flush,
//   accept+deliver in ONE, mid-operation reset and (with PIPE_STAGE_PERF_EN)
//   the saturating counters.

module tb_pipe_stage_skid_reg;

  localparam int unsigned DATA_W  = 32;
  localparam logic [DATA_W-1:0] RST_VAL = 32'hDEAD_BEEF;
`ifdef PIPE_STAGE_PERF_EN
  localparam int unsigned CNT_W   = 4;
`endif

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;
`endif

  int total;
  int bad;
  logic [DATA_W-1:0] sb[$];

  pipe_stage_skid_reg #(
    .DATA_W  (DATA_W),
    .RST_VAL (RST_VAL)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .CNT_W   (CNT_W)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: values are stable at negedge and describe the coming edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          check("sb_data", 64'(out_data), 64'(sb.pop_front()));
        end
      end
      if (flush) begin
        sb.delete();
      end else if (in_valid && in_ready) begin
        sb.push_back(in_data);
      end
    end
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  guard;
    logic rdy;
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset asserted mid-cycle takes effect without a clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_data",  64'(out_data),  64'(RST_VAL));
    @(negedge clk);
    rst = 1'b0;
    step();
    step();
    step();
`ifdef PIPE_STAGE_PERF_EN
    check("perf_bubble_idle", 64'(bubble_cnt), 64'd3);
    check("perf_stall_idle",  64'(stall_cnt),  64'd0);
`endif

    // Streaming: 1..8 back to back, one-cycle latency.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(i);
      if (i > 1) begin
        check("stream_out_valid", 64'(out_valid), 64'd1);
        check("stream_latency",   64'(out_data),  64'(i - 1));
      end
      check("stream_in_ready", 64'(in_ready), 64'd1);
      step();
    end
    in_valid = 1'b0;
    check("stream_last", 64'(out_data), 64'h8);
    check("stream_last_valid", 64'(out_valid), 64'd1);
    step();
    check("stream_drained", 64'(out_valid), 64'd0);

    // Backpressure: A, B, C with downstream stalled after A arrives.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    step();
    in_data = 32'hB;
    check("bp_ready_one", 64'(in_ready), 64'd1);
    step();
    in_data = 32'hC;
    check("bp_ready_low", 64'(in_ready), 64'd0);
    check("bp_hold_a",    64'(out_data), 64'hA);
    step();
    check("bp_ready_low2", 64'(in_ready), 64'd0);
    check("bp_hold_a2",    64'(out_data), 64'hA);
    out_ready = 1'b1;
    guard = 0;
    forever begin
      rdy = in_ready;
      step();
      if (rdy) break;
      guard++;
      if (guard > 20) begin
        check("bp_accept_timeout", 64'd1, 64'd0);
        break;
      end
    end
    in_valid = 1'b0;
    step();
    step();
    check("bp_drained", 64'(out_valid), 64'd0);
    check("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Accept and deliver together in ONE.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h5;
    step();
    in_valid = 1'b0;
    step();
    check("ad_hold5", 64'(out_data), 64'h5);
    in_valid  = 1'b1;
    in_data   = 32'h6;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("ad_valid",    64'(out_valid), 64'd1);
    check("ad_data6",    64'(out_data),  64'h6);
    check("ad_still_one", 64'(in_ready), 64'd1);
    step();
    check("ad_drained", 64'(out_valid), 64'd0);

    // Flush in TWO with a live input that must be discarded.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h21;
    step();
    in_data = 32'h22;
    step();
    check("fl_two_ready", 64'(in_ready), 64'd0);
    check("fl_two_data",  64'(out_data), 64'h21);
    in_data = 32'hD;
    flush   = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_in_ready",  64'(in_ready),  64'd1);
    out_ready = 1'b1;
    step();
    step();
    step();
    check("fl_no_d", 64'(out_valid), 64'd0);
    in_valid = 1'b1;
    in_data  = 32'h31;
    step();
    in_valid = 1'b0;
    check("fl_recover", 64'(out_data), 64'h31);
    step();

    // Flush in ONE: the concurrent delivery still counts, the input is lost.
    in_valid = 1'b1;
    in_data  = 32'h41;
    step();
    in_data = 32'h42;
    flush   = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl1_out_valid", 64'(out_valid), 64'd0);
    step();
    check("fl1_no_42", 64'(out_valid), 64'd0);

    // Reset mid-operation with two entries held.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h51;
    step();
    in_data = 32'h52;
    step();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    sb.delete();
    #1;
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_in_ready",  64'(in_ready),  64'd1);
    check("mrst_out_data",  64'(out_data),  64'(RST_VAL));
    @(negedge clk);
    rst = 1'b0;

    // Stall counter saturation after a fresh reset.
    in_valid = 1'b1;
    in_data  = 32'h61;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
`ifdef PIPE_STAGE_PERF_EN
    check("perf_stall_sat", 64'(stall_cnt),  64'd15);
    check("perf_bubble",    64'(bubble_cnt), 64'd1);
`endif
    check("stall_hold", 64'(out_data), 64'h61);
    out_ready = 1'b1;
    step();
    step();
    check("end_drained", 64'(out_valid), 64'd0);
    check("end_sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
